mdu_unit: RTL and testbench
===========================

// Module: mdu_unit
// PURPOSE
//   Multi-cycle multiply/divide unit with HI/LO registers. It is the sequential partner of the
//   single-cycle ALU: the datapath issues operands and an op with a start pulse, and the unit
//   answers with a busy window followed by a committed HI/LO result. It sits in EX beside the ALU.
//   The datapath stalls any MDU-dependent instruction while MDUBusy is high.
// PARAMETERS
//   MULT_CYCLES  5   cycles MDUBusy stays high for MULT/MULTU (>=1)
//   DIV_CYCLES   10  cycles MDUBusy stays high for DIV/DIVU (>=1)
// PORTS
//   clk       in   1   system clock, rising-edge
//   reset     in   1   asynchronous, active-low reset (0 = reset asserted)
//   MDUStart  in   1   one-cycle request strobe; sampled on rising clk
//   MDUOp     in   3   0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7=no-op
//   MDUSrcA   in   32  rs operand (dividend / multiplicand / MTHI-MTLO data)
//   MDUSrcB   in   32  rt operand (divisor / multiplier)
//   MDUBusy   out  1   high while a mult/div is in flight
//   HI        out  32  HI register
//   LO        out  32  LO register
// BEHAVIOUR
//   Reset (reset==0, async): state=IDLE, counter=0, MDUBusy=0, HI=0, LO=0, pending result=0.
//     Reset mid-operation aborts the op; HI/LO return to 0 and nothing is committed afterwards.
//   FSM states: IDLE, BUSY.
//     IDLE, MDUStart=1, MDUOp in {0..3}: latch computed result into pending regs, load counter
//       with MULT_CYCLES or DIV_CYCLES, go BUSY. MDUBusy rises on the same edge.
//     IDLE, MDUStart=1, MDUOp=4: HI<=MDUSrcA next edge. For MDUOp=5: LO<=MDUSrcA. No busy.
//     IDLE, MDUStart=1, MDUOp in {6,7}: ignored.
//     BUSY: counter decrements each edge. On the edge where counter==1: HI/LO<=pending,
//       MDUBusy<=0, go IDLE. MDUBusy is therefore high for exactly N cycles (N=MULT/DIV_CYCLES),
//       and the new HI/LO are visible in the same cycle MDUBusy first reads 0.
//     BUSY, MDUStart=1 (any op, including MTHI/MTLO): ignored. No queueing. HI/LO keep their
//       old values until commit.
//   Arithmetic (computed from operands sampled at start; later operand changes have no effect):
//     MULT : {HI,LO} = signed(A)*signed(B), 64-bit product.
//     MULTU: {HI,LO} = A*B unsigned, 64-bit product.
//     DIV  : LO = signed quotient, truncated toward zero; HI = remainder with the sign of A.
//     DIVU : LO = A/B, HI = A%B unsigned.
//     Divide by zero (B==0, DIV or DIVU): still takes DIV_CYCLES; commits LO=32'hFFFF_FFFF, HI=A.
//     DIV overflow (A=32'h8000_0000, B=32'hFFFF_FFFF): LO=32'h8000_0000, HI=0.
//   Back-to-back ops: a start in the cycle immediately after MDUBusy falls is accepted.
//   Outputs are registered; no combinational path from inputs to MDUBusy/HI/LO.
// TESTING
//   1. Hold reset=0, then release -> HI=0, LO=0, MDUBusy=0; MDUStart while reset=0 has no effect.
//   2. MULT with A=-3 (32'hFFFF_FFFD), B=7 -> MDUBusy high for 5 cycles;
//      then HI=32'hFFFF_FFFF, LO=32'hFFFF_FFEB.
//   3. MULTU with A=32'hFFFF_FFFF, B=2 -> HI=1, LO=32'hFFFF_FFFE.
//   4. DIV with A=-7, B=2 -> MDUBusy high for 10 cycles; LO=32'hFFFF_FFFD (-3), HI=32'hFFFF_FFFF (-1).
//      DIVU with A=7, B=0 -> LO=32'hFFFF_FFFF, HI=7.
//   5. Start DIVU 20/3, pulse MTHI with A=5 at busy cycle 3, change operands mid-op -> MTHI ignored;
//      commits LO=6, HI=2.
//   6. Start MULT, assert reset=0 at busy cycle 2 -> MDUBusy=0 and HI=LO=0 immediately;
//      after release, no late commit; MTLO A=32'h1234 -> LO=32'h1234 the next cycle.

Source files
------------

// File: rtl/mdu_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO. Results commit MULT_CYCLES/DIV_CYCLES edges after start.
// A start that arrives while busy is dropped. MTHI/MTLO write on the next edge and only when idle.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MDUStart,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] MDUSrcA,
    input  logic [31:0] MDUSrcB,
    output logic        MDUBusy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic {IDLE, BUSY} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

    logic [63:0] prod_s, prod_u;
    logic        neg_a, neg_b, b_zero;
    logic [31:0] mag_a, mag_b, div_b, q_mag, r_mag, q_res, r_res, div_hi, div_lo;

    // Lower 64 bits of the sign-extended product equal the signed 32x32 product.
    assign prod_s = {{32{MDUSrcA[31]}}, MDUSrcA} * {{32{MDUSrcB[31]}}, MDUSrcB};
    assign prod_u = {32'd0, MDUSrcA} * {32'd0, MDUSrcB};

    // One unsigned divider serves both divides; signed DIV works on magnitudes.
    assign neg_a  = (MDUOp == OP_DIV) && MDUSrcA[31];
    assign neg_b  = (MDUOp == OP_DIV) && MDUSrcB[31];
    assign b_zero = (MDUSrcB == 32'd0);
    assign mag_a  = neg_a ? (~MDUSrcA + 32'd1) : MDUSrcA;
    assign mag_b  = neg_b ? (~MDUSrcB + 32'd1) : MDUSrcB;
    assign div_b  = b_zero ? 32'd1 : mag_b;
    assign q_mag  = mag_a / div_b;
    assign r_mag  = mag_a % div_b;
    assign q_res  = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
    assign r_res  = neg_a ? (~r_mag + 32'd1) : r_mag;
    assign div_lo = b_zero ? 32'hFFFF_FFFF : q_res;
    assign div_hi = b_zero ? MDUSrcA : r_res;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        case (state_q)
            IDLE: begin
                if (MDUStart) begin
                    case (MDUOp)
                        OP_MULT: begin
                            {pend_hi_d, pend_lo_d} = prod_s;
                            cnt_d   = MULT_LOAD;
                            state_d = BUSY;
                        end
                        OP_MULTU: begin
                            {pend_hi_d, pend_lo_d} = prod_u;
                            cnt_d   = MULT_LOAD;
                            state_d = BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            pend_hi_d = div_hi;
                            pend_lo_d = div_lo;
                            cnt_d     = DIV_LOAD;
                            state_d   = BUSY;
                        end
                        OP_MTHI: hi_d = MDUSrcA;
                        OP_MTLO: lo_d = MDUSrcA;
                        default: ;
                    endcase
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    assign MDUBusy = (state_q == BUSY);
    assign HI      = hi_q;
    assign LO      = lo_q;
endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: reset, mult/div results and busy length, busy-time MTHI, mid-op reset.
module tb_mdu_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MDUStart = 1'b0;
    logic [2:0]  MDUOp = 3'd7;
    logic [31:0] MDUSrcA = 32'd0;
    logic [31:0] MDUSrcB = 32'd0;
    logic        MDUBusy;
    logic [31:0] HI, LO;

    int checks = 0;
    int errors = 0;

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .MDUStart(MDUStart), .MDUOp(MDUOp),
        .MDUSrcA(MDUSrcA), .MDUSrcB(MDUSrcB),
        .MDUBusy(MDUBusy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        MDUOp    = op;
        MDUSrcA  = a;
        MDUSrcB  = b;
        MDUStart = 1'b1;
        tick();
        MDUStart = 1'b0;
    endtask

    // Counts samples with MDUBusy high, starting from the current one; bounded.
    task automatic wait_idle(input string tag, input int exp_cycles);
        int n = 0;
        while (MDUBusy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        check(tag, 32'(n), 32'(exp_cycles));
    endtask

    initial begin
        #2 reset = 1'b0;
        MDUStart = 1'b1;
        MDUOp    = 3'd5;
        MDUSrcA  = 32'h0000_1234;
        #1;
        check("rst_async_busy", {31'd0, MDUBusy}, 32'd0);
        tick();
        tick();
        check("rst_hold_lo", LO, 32'd0);
        MDUStart = 1'b0;
        reset = 1'b1;
        tick();
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        check("rst_busy", {31'd0, MDUBusy}, 32'd0);

        // MULT -3 * 7
        start_op(3'd0, 32'hFFFF_FFFD, 32'd7);
        check("mult_busy_rise", {31'd0, MDUBusy}, 32'd1);
        check("mult_hi_held", HI, 32'd0);
        MDUSrcA = 32'd100;
        wait_idle("mult_cycles", 5);
        check("mult_hi", HI, 32'hFFFF_FFFF);
        check("mult_lo", LO, 32'hFFFF_FFEB);

        // MULTU issued in the cycle right after busy falls
        start_op(3'd1, 32'hFFFF_FFFF, 32'd2);
        check("multu_b2b_busy", {31'd0, MDUBusy}, 32'd1);
        wait_idle("multu_cycles", 5);
        check("multu_hi", HI, 32'd1);
        check("multu_lo", LO, 32'hFFFF_FFFE);

        // DIV -7 / 2
        start_op(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_idle("div_cycles", 10);
        check("div_lo", LO, 32'hFFFF_FFFD);
        check("div_hi", HI, 32'hFFFF_FFFF);

        // DIV 7 / -2: remainder follows dividend sign
        start_op(3'd2, 32'd7, 32'hFFFF_FFFE);
        wait_idle("div2_cycles", 10);
        check("div2_lo", LO, 32'hFFFF_FFFD);
        check("div2_hi", HI, 32'd1);

        // DIV overflow
        start_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle("divovf_cycles", 10);
        check("divovf_lo", LO, 32'h8000_0000);
        check("divovf_hi", HI, 32'd0);

        // DIVU by zero
        start_op(3'd3, 32'd7, 32'd0);
        wait_idle("divz_cycles", 10);
        check("divz_lo", LO, 32'hFFFF_FFFF);
        check("divz_hi", HI, 32'd7);

        // No-op opcode leaves everything alone
        start_op(3'd6, 32'hDEAD_BEEF, 32'd1);
        check("nop_busy", {31'd0, MDUBusy}, 32'd0);
        check("nop_hi", HI, 32'd7);
        check("nop_lo", LO, 32'hFFFF_FFFF);

        // DIVU 20/3 with MTHI at busy cycle 3 and operand changes mid-op
        start_op(3'd3, 32'd20, 32'd3);
        tick();
        tick();
        MDUOp    = 3'd4;
        MDUSrcA  = 32'd5;
        MDUSrcB  = 32'd99;
        MDUStart = 1'b1;
        tick();
        MDUStart = 1'b0;
        MDUSrcA  = 32'd100;
        MDUSrcB  = 32'd1;
        check("busy_mthi_ignored", HI, 32'd7);
        wait_idle("divu_rest_cycles", 7);
        check("divu_lo", LO, 32'd6);
        check("divu_hi", HI, 32'd2);

        // MTHI while idle
        start_op(3'd4, 32'h0000_ABCD, 32'd0);
        check("mthi_hi", HI, 32'h0000_ABCD);
        check("mthi_busy", {31'd0, MDUBusy}, 32'd0);

        // Reset in the middle of a MULT
        start_op(3'd0, 32'd3, 32'd4);
        tick();
        reset = 1'b0;
        #1;
        check("midrst_busy", {31'd0, MDUBusy}, 32'd0);
        check("midrst_hi", HI, 32'd0);
        check("midrst_lo", LO, 32'd0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check("norelate_busy", {31'd0, MDUBusy}, 32'd0);
        check("norelate_hi", HI, 32'd0);
        check("norelate_lo", LO, 32'd0);

        start_op(3'd5, 32'h0000_1234, 32'd0);
        check("mtlo_lo", LO, 32'h0000_1234);
        check("mtlo_hi", HI, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
